// File: rtl/knn_stream_sorter_if.sv
// Data-point stream between the fetch unit (master) and the KNN sorter (slave).
interface knn_stream_sorter_if #(
  parameter int COORD_W = 16,
  parameter int LABEL_W = 8
);
  logic                      dp_valid;
  logic                      dp_ready;
  logic signed [COORD_W-1:0] dp_x;
  logic signed [COORD_W-1:0] dp_y;
  logic        [LABEL_W-1:0] dp_label;

  modport master (output dp_valid, dp_x, dp_y, dp_label, input dp_ready);
  modport slave  (input dp_valid, dp_x, dp_y, dp_label, output dp_ready);
endinterface

// File: rtl/knn_stream_sorter.sv
// Streaming k-nearest-neighbour engine: two-stage distance pipeline feeding a
// sorted K-entry insertion list with stable ordering on equal distances.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; outputs hold the previous query result
// RUN    | accepting data points until n_points have been taken
// DRAIN  | waiting for the distance pipeline to empty (two cycles minimum)
// DONE   | one-cycle done pulse, list final
module knn_stream_sorter #(
  parameter  int COORD_W = 16,
  parameter  int LABEL_W = 8,
  parameter  int K       = 4,
  parameter  int CNT_W   = 16,
  localparam int DIST_W  = 2*COORD_W+3,
  localparam int NC_W    = $clog2(K+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [COORD_W-1:0] test_x,
  input  logic signed [COORD_W-1:0] test_y,
  input  logic                      metric,
  input  logic        [CNT_W-1:0]   n_points,
  knn_stream_sorter_if.slave        dp,
  output logic                      busy,
  output logic                      done,
  output logic        [NC_W-1:0]    nb_count,
  output logic        [K*DIST_W-1:0]  nb_dist,
  output logic        [K*LABEL_W-1:0] nb_label
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                    state, state_nx;
  logic signed [COORD_W-1:0] tx_q, ty_q;
  logic                      metric_q;
  logic        [CNT_W-1:0]   npts_q, acc_q;
  logic                      ready_q;
  logic                      drain_fresh;
  logic                      hs, last_hs;

  logic                      s1_v, s2_v;
  logic signed [COORD_W:0]   dx_q, dy_q;
  logic        [LABEL_W-1:0] s1_lab, s2_lab;
  logic        [DIST_W-1:0]  s2_dist;

  logic        [DIST_W-1:0]  lst_d [K];
  logic        [LABEL_W-1:0] lst_l [K];
  logic        [NC_W-1:0]    cnt_q;

  assign hs      = (state == S_RUN) && ready_q && dp.dp_valid;
  assign last_hs = hs && ((acc_q + CNT_W'(1)) == npts_q);
  assign dp.dp_ready = ready_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (n_points == '0) ? S_DRAIN : S_RUN;
      S_RUN:   if (last_hs) state_nx = S_DRAIN;
      S_DRAIN: if (!drain_fresh && !s1_v && !s2_v) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Query parameters, accepted counter and registered ready flag.
  // drain_fresh marks the first DRAIN cycle so an empty query still spends
  // two cycles draining.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_q        <= '0;
      ty_q        <= '0;
      metric_q    <= 1'b0;
      npts_q      <= '0;
      acc_q       <= '0;
      ready_q     <= 1'b0;
      drain_fresh <= 1'b0;
    end else begin
      drain_fresh <= (state_nx == S_DRAIN) && (state != S_DRAIN);
      if (state == S_IDLE && start) begin
        tx_q     <= test_x;
        ty_q     <= test_y;
        metric_q <= metric;
        npts_q   <= n_points;
        acc_q    <= '0;
        ready_q  <= (n_points != '0);
      end else if (hs) begin
        acc_q   <= acc_q + CNT_W'(1);
        ready_q <= !last_hs;
      end
    end
  end

  // Stage 1: coordinate differences, one bit wider so they cannot overflow
  logic signed [COORD_W:0] dx_c, dy_c;
  assign dx_c = {tx_q[COORD_W-1], tx_q} - {dp.dp_x[COORD_W-1], dp.dp_x};
  assign dy_c = {ty_q[COORD_W-1], ty_q} - {dp.dp_y[COORD_W-1], dp.dp_y};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v   <= 1'b0;
      dx_q   <= '0;
      dy_q   <= '0;
      s1_lab <= '0;
    end else begin
      s1_v <= hs;
      if (hs) begin
        dx_q   <= dx_c;
        dy_q   <= dy_c;
        s1_lab <= dp.dp_label;
      end
    end
  end

  // Stage 2: distance. Operands are sign-extended to the product width so the
  // low bits of the unsigned product equal the (non-negative) square.
  logic [2*COORD_W+1:0] dxe, dye, sqx, sqy;
  logic [COORD_W:0]     adx, ady;
  logic [DIST_W-1:0]    dist_c;

  always_comb begin
    dxe    = {{(COORD_W+1){dx_q[COORD_W]}}, dx_q};
    dye    = {{(COORD_W+1){dy_q[COORD_W]}}, dy_q};
    sqx    = dxe * dxe;
    sqy    = dye * dye;
    adx    = dx_q[COORD_W] ? (~dx_q + (COORD_W+1)'(1)) : dx_q;
    ady    = dy_q[COORD_W] ? (~dy_q + (COORD_W+1)'(1)) : dy_q;
    dist_c = metric_q ? (DIST_W'(adx) + DIST_W'(ady))
                      : (DIST_W'(sqx) + DIST_W'(sqy));
  end

  // Stage 2 register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_v    <= 1'b0;
      s2_dist <= '0;
      s2_lab  <= '0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_dist <= dist_c;
        s2_lab  <= s1_lab;
      end
    end
  end

  // Stage 3 insertion. le_ext[i+1] flags valid entries at or below the new
  // distance; because the list is sorted this is a prefix, so the new entry
  // lands at the first cleared position after all equal entries (stable).
  logic [K:0]         le_ext;
  logic [DIST_W-1:0]  sh_d [K];
  logic [LABEL_W-1:0] sh_l [K];
  logic [DIST_W-1:0]  nx_d [K];
  logic [LABEL_W-1:0] nx_l [K];
  logic [NC_W-1:0]    cnt_nx;

  always_comb begin
    le_ext[0] = 1'b1;
    for (int i = 0; i < K; i++)
      le_ext[i+1] = (NC_W'(i) < cnt_q) && (lst_d[i] <= s2_dist);
    sh_d[0] = '0;
    sh_l[0] = '0;
    for (int i = 1; i < K; i++) begin
      sh_d[i] = lst_d[i-1];
      sh_l[i] = lst_l[i-1];
    end
    for (int i = 0; i < K; i++) begin
      if (le_ext[i+1]) begin
        nx_d[i] = lst_d[i];
        nx_l[i] = lst_l[i];
      end else if (le_ext[i]) begin
        nx_d[i] = s2_dist;
        nx_l[i] = s2_lab;
      end else begin
        nx_d[i] = sh_d[i];
        nx_l[i] = sh_l[i];
      end
    end
    if (le_ext[K] || cnt_q == NC_W'(K)) cnt_nx = cnt_q;
    else                                cnt_nx = cnt_q + NC_W'(1);
  end

  // Neighbour list storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      for (int i = 0; i < K; i++) begin
        lst_d[i] <= '0;
        lst_l[i] <= '0;
      end
    end else if (state == S_IDLE && start) begin
      cnt_q <= '0;
    end else if (s2_v) begin
      cnt_q <= cnt_nx;
      for (int i = 0; i < K; i++) begin
        lst_d[i] <= nx_d[i];
        lst_l[i] <= nx_l[i];
      end
    end
  end

  // Pack list onto output buses
  always_comb begin
    nb_count = cnt_q;
    for (int i = 0; i < K; i++) begin
      nb_dist[i*DIST_W +: DIST_W]   = lst_d[i];
      nb_label[i*LABEL_W +: LABEL_W] = lst_l[i];
    end
  end

endmodule

// File: tb/tb_knn_stream_sorter.sv
// Scenario bench for knn_stream_sorter with a queue scoreboard: expected lists
// are computed from a reference sort at start and checked at done.
module tb_knn_stream_sorter;
  localparam int COORD_W = 16;
  localparam int LABEL_W = 8;
  localparam int K       = 4;
  localparam int CNT_W   = 16;
  localparam int DIST_W  = 2*COORD_W+3;
  localparam int NC_W    = $clog2(K+1);

  logic clk = 1'b0;
  logic rst;
  logic start, metric;
  logic signed [COORD_W-1:0] test_x, test_y;
  logic [CNT_W-1:0] n_points;
  logic busy, done;
  logic [NC_W-1:0] nb_count;
  logic [K*DIST_W-1:0] nb_dist;
  logic [K*LABEL_W-1:0] nb_label;

  knn_stream_sorter_if #(.COORD_W(COORD_W), .LABEL_W(LABEL_W)) dpif();

  knn_stream_sorter #(.COORD_W(COORD_W), .LABEL_W(LABEL_W), .K(K), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .test_x(test_x), .test_y(test_y),
    .metric(metric), .n_points(n_points), .dp(dpif), .busy(busy), .done(done),
    .nb_count(nb_count), .nb_dist(nb_dist), .nb_label(nb_label)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                   cnt;
    logic [K*DIST_W-1:0]  d;
    logic [K*LABEL_W-1:0] l;
  } exp_t;

  exp_t sb[$];
  int px[$], py[$], pl[$];
  int checks = 0, passed = 0;

  // Reference: compute every distance, then stable selection sort.
  function automatic exp_t model(input int tx, input int ty, input bit met);
    exp_t   e;
    longint dd [64];
    bit     used [64];
    longint ax, ay, v;
    int     n, b;
    n = px.size();
    e.cnt = (n < K) ? n : K;
    e.d = '0;
    e.l = '0;
    for (int i = 0; i < n; i++) begin
      ax = longint'(tx) - longint'(px[i]);
      ay = longint'(ty) - longint'(py[i]);
      if (met) dd[i] = (ax < 0 ? -ax : ax) + (ay < 0 ? -ay : ay);
      else     dd[i] = ax*ax + ay*ay;
      used[i] = 1'b0;
    end
    for (int k = 0; k < e.cnt; k++) begin
      b = -1;
      for (int i = 0; i < n; i++)
        if (!used[i] && (b < 0 || dd[i] < dd[b])) b = i;
      used[b] = 1'b1;
      v = dd[b];
      e.d[k*DIST_W +: DIST_W] = v[DIST_W-1:0];
      e.l[k*LABEL_W +: LABEL_W] = LABEL_W'(pl[b]);
    end
    return e;
  endfunction

  task automatic load_base();
    px = '{3, 1, -2, 10, 0};
    py = '{4, 1, 0, 10, 1};
    pl = '{1, 2, 3, 4, 5};
  endtask

  task automatic do_start(input int tx, input int ty, input bit met, output int c0);
    @(negedge clk);
    test_x = COORD_W'(tx); test_y = COORD_W'(ty); metric = met;
    n_points = CNT_W'(px.size());
    start = 1'b1;
    sb.push_back(model(tx, ty, met));
    @(posedge clk); #1;
    c0 = cyc;
    start = 1'b0;
  endtask

  // Sends up to max_hs points; optional random valid gaps; optional start
  // pulse (with bogus query inputs) while point start_at is offered.
  task automatic send_points(input int max_hs, input bit gaps, input int start_at,
                             output int c_last, output bit ok);
    int i, budget;
    bit hs;
    i = 0; budget = 0; ok = 1'b1; c_last = 0;
    while (i < max_hs) begin
      @(negedge clk);
      budget++;
      if (budget > 500) begin ok = 1'b0; break; end
      if (gaps && $urandom_range(0, 2) == 0) begin
        dpif.dp_valid = 1'b0;
      end else begin
        dpif.dp_valid = 1'b1;
        dpif.dp_x = COORD_W'(px[i]);
        dpif.dp_y = COORD_W'(py[i]);
        dpif.dp_label = LABEL_W'(pl[i]);
      end
      if (i == start_at) begin
        start = 1'b1; test_x = 100; test_y = -100; metric = ~metric; n_points = 1;
      end else begin
        start = 1'b0;
      end
      hs = dpif.dp_valid && dpif.dp_ready;
      @(posedge clk); #1;
      if (hs) begin c_last = cyc; i++; end
    end
    dpif.dp_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cd, output bit ok);
    ok = 1'b0; cd = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (done) begin cd = cyc; ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dpif.dp_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", dpif.dp_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (nb_count !== '0) $display("FAIL reset_count got %0d want 0", nb_count); else passed++;
    checks++; if (nb_dist !== '0) $display("FAIL reset_dist got %h want 0", nb_dist); else passed++;
    checks++; if (nb_label !== '0) $display("FAIL reset_label got %h want 0", nb_label); else passed++;
    rst = 1'b1;
  endtask

  // Full query on the base points; start_at>=0 also pulses start mid-RUN.
  task automatic test_base(input bit met, input int start_at, input string nm);
    int c0, cl, cd;
    bit ok;
    exp_t e;
    load_base();
    do_start(0, 0, met, c0);
    checks++; if (busy !== 1'b1 || dpif.dp_ready !== 1'b1)
      $display("FAIL %s_startflags got busy=%b ready=%b want 1/1", nm, busy, dpif.dp_ready); else passed++;
    send_points(5, 1'b0, start_at, cl, ok);
    checks++; if (!ok) $display("FAIL %s_send got timeout want 5 handshakes", nm); else passed++;
    checks++; if (cl != c0 + 5) $display("FAIL %s_b2b got last hs cycle %0d want %0d", nm, cl, c0 + 5); else passed++;
    wait_done(cd, ok);
    checks++; if (!ok || cd != cl + 3) $display("FAIL %s_latency got ok=%b cycle %0d want %0d", nm, ok, cd, cl + 3); else passed++;
    e = sb.pop_front();
    checks++; if (nb_count !== NC_W'(e.cnt)) $display("FAIL %s_count got %0d want %0d", nm, nb_count, e.cnt); else passed++;
    for (int k = 0; k < e.cnt; k++) begin
      checks++; if (nb_dist[k*DIST_W +: DIST_W] !== e.d[k*DIST_W +: DIST_W] ||
                    nb_label[k*LABEL_W +: LABEL_W] !== e.l[k*LABEL_W +: LABEL_W])
        $display("FAIL %s_entry%0d got d=%0d l=%0d want d=%0d l=%0d", nm, k,
                 nb_dist[k*DIST_W +: DIST_W], nb_label[k*LABEL_W +: LABEL_W],
                 e.d[k*DIST_W +: DIST_W], e.l[k*LABEL_W +: LABEL_W]);
      else passed++;
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s_pulse got done=%b busy=%b want 0/0", nm, done, busy); else passed++;
  endtask

  task automatic test_gaps();
    int c0, cl, cd;
    bit ok;
    exp_t e;
    px = '{2, 1}; py = '{0, 0}; pl = '{7, 8};
    do_start(0, 0, 1'b0, c0);
    send_points(2, 1'b1, -1, cl, ok);
    checks++; if (!ok) $display("FAIL gaps_send got timeout want 2 handshakes"); else passed++;
    checks++; if (dpif.dp_ready !== 1'b0) $display("FAIL gaps_ready got %b want 0", dpif.dp_ready); else passed++;
    wait_done(cd, ok);
    checks++; if (!ok || cd != cl + 3) $display("FAIL gaps_latency got ok=%b cycle %0d want %0d", ok, cd, cl + 3); else passed++;
    e = sb.pop_front();
    checks++; if (nb_count !== NC_W'(e.cnt)) $display("FAIL gaps_count got %0d want %0d", nb_count, e.cnt); else passed++;
    for (int k = 0; k < e.cnt; k++) begin
      checks++; if (nb_dist[k*DIST_W +: DIST_W] !== e.d[k*DIST_W +: DIST_W] ||
                    nb_label[k*LABEL_W +: LABEL_W] !== e.l[k*LABEL_W +: LABEL_W])
        $display("FAIL gaps_entry%0d got d=%0d l=%0d want d=%0d l=%0d", k,
                 nb_dist[k*DIST_W +: DIST_W], nb_label[k*LABEL_W +: LABEL_W],
                 e.d[k*DIST_W +: DIST_W], e.l[k*LABEL_W +: LABEL_W]);
      else passed++;
    end
  endtask

  task automatic test_extremes();
    int c0, cl, cd;
    bit ok;
    exp_t e;
    logic [DIST_W-1:0] big;
    big = 35'd8589672450;
    px = '{-32768}; py = '{-32768}; pl = '{9};
    do_start(32767, 32767, 1'b0, c0);
    send_points(1, 1'b0, -1, cl, ok);
    wait_done(cd, ok);
    e = sb.pop_front();
    checks++; if (!ok || nb_count !== NC_W'(e.cnt)) $display("FAIL extreme_count got ok=%b %0d want %0d", ok, nb_count, e.cnt); else passed++;
    checks++; if (nb_dist[DIST_W-1:0] !== big || nb_dist[DIST_W-1:0] !== e.d[DIST_W-1:0])
      $display("FAIL extreme_dist got %0d want %0d", nb_dist[DIST_W-1:0], big); else passed++;
    px.delete(); py.delete(); pl.delete();
    do_start(0, 0, 1'b0, c0);
    wait_done(cd, ok);
    e = sb.pop_front();
    checks++; if (!ok || cd != c0 + 2) $display("FAIL empty_latency got ok=%b cycle %0d want %0d", ok, cd, c0 + 2); else passed++;
    checks++; if (nb_count !== NC_W'(e.cnt)) $display("FAIL empty_count got %0d want %0d", nb_count, e.cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    int c0, cl, seen;
    bit ok;
    exp_t e;
    load_base();
    do_start(0, 0, 1'b0, c0);
    send_points(2, 1'b0, -1, cl, ok);
    rst = 1'b0;
    #1;
    e = sb.pop_back();
    checks++; if (dpif.dp_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL midrst_ctrl got ready=%b busy=%b done=%b want 0/0/0", dpif.dp_ready, busy, done); else passed++;
    checks++; if (nb_count !== '0 || nb_dist !== '0 || nb_label !== '0)
      $display("FAIL midrst_list got count=%0d dist=%h label=%h want 0", nb_count, nb_dist, nb_label); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++; if (seen != 0) $display("FAIL midrst_nodone got %0d active cycles want 0", seen); else passed++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0; metric = 1'b0; test_x = '0; test_y = '0; n_points = '0;
    dpif.dp_valid = 1'b0; dpif.dp_x = '0; dpif.dp_y = '0; dpif.dp_label = '0;
    test_reset();
    test_base(1'b0, -1, "euclid");
    test_base(1'b1, -1, "manhattan");
    test_gaps();
    test_extremes();
    test_reset_mid();
    test_base(1'b0, 2, "rerun");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
